// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding control slice.
// Encodings here are visible on the EX operand mux select lines.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// EX operand bypass select for one source register; purely combinational.
// No backpressure: the select follows the current MEM/WB/EX fields.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_we_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_we_i,
    output fwd_sel_e         sel_o
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it must never be bypassed.
    assign mem_hit = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
    assign wb_hit  = wb_we_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / flush bubble control, EX bypass selects and event counters.
// Stall/Bubble/Forward are combinational; Stall freezes PC and IF/ID for one cycle.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic [REG_W-1:0] EX_rs1,
    input  logic [REG_W-1:0] EX_rs2,
    input  logic             EX_RegWrite,
    input  logic             EX_MemToReg,
    input  logic             Flush,
    output logic             Stall,
    output logic             Bubble,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    hz_state_e        state_q, state_d;
    logic [REG_W-1:0] mem_rd_q, wb_rd_q;
    logic             mem_we_q, wb_we_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             stall_raw, bubble_raw;
    fwd_sel_e         fwd_a, fwd_b;

    assign hazard = EX_MemToReg && EX_RegWrite && (EX_rd != '0) &&
                    ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));

    always_comb begin
        state_d    = RUN;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        case (state_q)
            RUN: begin
                if (Flush) begin
                    bubble_raw = 1'b1;
                end else if (hazard) begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // The load has moved to MEM; its result is now bypassable.
                bubble_raw = Flush;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs read zero for the whole time reset is held, not just after an edge.
    assign Stall  = rst_n && stall_raw;
    assign Bubble = rst_n && bubble_raw;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (Flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // EX fields shift every cycle; a bubble arrives as zeroed controls next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_rd_q    <= EX_rd;
            mem_we_q    <= EX_RegWrite;
            wb_rd_q     <= mem_rd_q;
            wb_we_q     <= mem_we_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs_i  (EX_rs1),
        .mem_rd_i (mem_rd_q),
        .mem_we_i (mem_we_q),
        .wb_rd_i  (wb_rd_q),
        .wb_we_i  (wb_we_q),
        .sel_o    (fwd_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs_i  (EX_rs2),
        .mem_rd_i (mem_rd_q),
        .mem_we_i (mem_we_q),
        .wb_rd_i  (wb_rd_q),
        .wb_we_i  (wb_we_q),
        .sel_o    (fwd_b)
    );

    assign ForwardA   = fwd_a;
    assign ForwardB   = fwd_b;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded directed bench for hazard_ctrl (narrow counters to reach saturation).
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [REG_W-1:0] ID_rs1 = '0, ID_rs2 = '0;
    logic [REG_W-1:0] EX_rd = '0, EX_rs1 = '0, EX_rs2 = '0;
    logic             EX_RegWrite = 1'b0, EX_MemToReg = 1'b0, Flush = 1'b0;
    logic             Stall, Bubble;
    logic [1:0]       ForwardA, ForwardB;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .EX_rd       (EX_rd),
        .EX_rs1      (EX_rs1),
        .EX_rs2      (EX_rs2),
        .EX_RegWrite (EX_RegWrite),
        .EX_MemToReg (EX_MemToReg),
        .Flush       (Flush),
        .Stall       (Stall),
        .Bubble      (Bubble),
        .ForwardA    (ForwardA),
        .ForwardB    (ForwardB),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        string name;
        int    st, bu, fa, fb, sc, fc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string n, input string f, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s got=%0d exp=%0d", n, f, got, want);
        end
    endtask

    // Monitor: compares the DUT outputs at the negedge of the stamped cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            cmp(e.name, "missed_cycle", cyc, e.cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            cmp(e.name, "Stall",      int'(Stall),      e.st);
            cmp(e.name, "Bubble",     int'(Bubble),     e.bu);
            cmp(e.name, "ForwardA",   int'(ForwardA),   e.fa);
            cmp(e.name, "ForwardB",   int'(ForwardB),   e.fb);
            cmp(e.name, "StallCount", int'(StallCount), e.sc);
            cmp(e.name, "FlushCount", int'(FlushCount), e.fc);
        end
    end

    task automatic drive(input int r1, input int r2, input int erd, input int ers1,
                         input int ers2, input bit rw, input bit m2r, input bit fl);
        @(posedge clk);
        #1;
        ID_rs1      = REG_W'(r1);
        ID_rs2      = REG_W'(r2);
        EX_rd       = REG_W'(erd);
        EX_rs1      = REG_W'(ers1);
        EX_rs2      = REG_W'(ers2);
        EX_RegWrite = rw;
        EX_MemToReg = m2r;
        Flush       = fl;
    endtask

    task automatic exp_out(input string n, input int st, input int bu, input int fa,
                           input int fb, input int sc, input int fc);
        exp_t e;
        e = '{cyc, n, st, bu, fa, fb, sc, fc};
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset held: hazard and flush inputs must not reach the outputs.
        drive(0, 5, 5, 0, 0, 1, 1, 1);  exp_out("rst_hz", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  rst_n = 1'b1;
        exp_out("rst_rel", 0, 0, 0, 0, 0, 0);

        // Load-use on rs2: one stall cycle, then bypass from WB after the bubble.
        drive(0, 5, 5, 0, 0, 1, 1, 0);  exp_out("lu_stall", 1, 1, 0, 0, 0, 0);
        drive(0, 5, 0, 0, 0, 0, 0, 0);  exp_out("lu_hold",  0, 0, 0, 0, 1, 0);
        drive(0, 0, 6, 0, 5, 1, 0, 0);  exp_out("lu_run",   0, 0, 0, 1, 1, 0);

        // x0 never stalls and is never forwarded.
        drive(0, 0, 0, 0, 0, 1, 1, 0);  exp_out("x0_load", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);  exp_out("x0_alu",  0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  exp_out("x0_fwd1", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  exp_out("x0_fwd2", 0, 0, 0, 0, 1, 0);

        // Two writes of x3: MEM wins; only the older one: WB.
        drive(0, 0, 3, 0, 0, 1, 0, 0);  exp_out("pri_w1",    0, 0, 0, 0, 1, 0);
        drive(0, 0, 3, 0, 0, 1, 0, 0);  exp_out("pri_w2",    0, 0, 0, 0, 1, 0);
        drive(0, 0, 4, 3, 7, 0, 0, 0);  exp_out("pri_mem",   0, 0, 2, 0, 1, 0);
        drive(0, 0, 3, 0, 0, 1, 0, 0);  exp_out("old_w",     0, 0, 0, 0, 1, 0);
        drive(0, 0, 8, 0, 0, 1, 0, 0);  exp_out("old_other", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 3, 3, 0, 0, 0);  exp_out("pri_wb",    0, 0, 1, 1, 1, 0);

        // Flush beats a load-use hazard; flush during HOLD still bubbles.
        drive(5, 0, 5, 0, 0, 1, 1, 1);  exp_out("fl_hz",       0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  exp_out("fl_after",    0, 0, 0, 0, 1, 1);
        drive(5, 0, 5, 0, 0, 1, 1, 0);  exp_out("hz2",         1, 1, 0, 0, 1, 1);
        drive(5, 0, 5, 0, 0, 1, 1, 1);  exp_out("fl_hold",     0, 1, 0, 0, 2, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  exp_out("fl_hold_run", 0, 0, 0, 0, 2, 2);

        // Reset asserted during HOLD clears outputs and counters immediately.
        drive(5, 0, 5, 0, 0, 1, 1, 0);  exp_out("rh_stall", 1, 1, 0, 0, 2, 2);
        drive(5, 0, 5, 5, 5, 1, 1, 1);  rst_n = 1'b0;
        exp_out("rh_reset", 0, 0, 0, 0, 0, 0);
        drive(5, 0, 5, 5, 0, 1, 1, 0);  rst_n = 1'b1;
        exp_out("rh_rel_stall", 1, 1, 0, 0, 0, 0);
        drive(5, 0, 5, 0, 0, 1, 1, 0);  exp_out("rh_hold", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  exp_out("rh_run",  0, 0, 0, 0, 1, 0);

        // Persistent hazard: stall/hold alternate, 20 stalls saturate a 4-bit counter.
        for (int i = 0; i < 40; i++) begin
            int sc_exp;
            drive(5, 0, 5, 0, 0, 1, 1, 0);
            if (i % 2 == 0) begin
                sc_exp = 1 + i / 2;
                exp_out("sat_stall", 1, 1, 0, 0, (sc_exp > 15) ? 15 : sc_exp, 0);
            end else begin
                sc_exp = 1 + (i + 1) / 2;
                exp_out("sat_hold", 0, 0, 0, 0, (sc_exp > 15) ? 15 : sc_exp, 0);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);  exp_out("sat_final", 0, 0, 0, 0, 15, 0);

        repeat (3) @(posedge clk);
        cmp("drain", "pending", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 5, register-index width.
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 ID_rs1, ID_rs2  in  REG_W each  source registers of the instruction currently in ID.
REQ-006 EX_rd, EX_rs1, EX_rs2  in  REG_W each  fields at the ID/EX register outputs.
REQ-007 EX_RegWrite, EX_MemToReg  in  1 each  EX-stage controls; MemToReg=1 marks a load.
REQ-008 Flush  in  1  branch/jump resolved taken in EX this cycle.
REQ-009 Stall  out  1  freeze the PC and IF/ID; hold ID inputs.
REQ-010 Bubble  out  1  force zero controls (RegWrite, MemWrite, MemToReg) into ID/EX at the next edge.
REQ-011 ForwardA, ForwardB  out  2 each  EX operand select: 00 register file, 10 MEM result, 01 WB result.
REQ-012 StallCount, FlushCount  out  CNT_W each  saturating event counters.

Function
REQ-013 The block SHALL track MEM_rd/MEM_RegWrite and WB_rd/WB_RegWrite internally by shifting EX_rd/EX_RegWrite, then MEM fields, at each posedge clk.
REQ-014 The block SHALL define a hazard as EX_MemToReg & EX_RegWrite & (EX_rd!=0) & (EX_rd==ID_rs1 | EX_rd==ID_rs2).
REQ-015 The FSM SHALL have exactly two states: RUN and HOLD.
REQ-016 In RUN with a hazard and Flush=0, the block SHALL drive Stall=1 and Bubble=1 combinationally in the same cycle and enter HOLD.
REQ-017 HOLD SHALL last exactly one cycle: Stall=0, Bubble=0, hazard detection suppressed, unconditional return to RUN.
REQ-018 When Flush=1, in either state, the block SHALL drive Bubble=1 and Stall=0, enter RUN, and take priority over the hazard.
REQ-019 ForwardA SHALL be 10 if MEM_RegWrite & MEM_rd!=0 & MEM_rd==EX_rs1; else 01 if WB_RegWrite & WB_rd!=0 & WB_rd==EX_rs1; else 00.
REQ-020 ForwardB SHALL follow the same rule against EX_rs2.
REQ-021 Forwarding SHALL be purely combinational from the current internal and EX state, with MEM taking priority over WB.
REQ-022 Register x0 SHALL never be forwarded nor cause a stall.
REQ-023 StallCount SHALL increment on each cycle with Stall=1, and FlushCount on each cycle with Flush=1.
REQ-024 Each counter SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 When a bubble is inserted, the internal MEM/WB tracking SHALL still shift the (zeroed) EX fields, so no stale forward occurs.

Reset
REQ-026 While rst_n=0, the block SHALL force state=RUN, MEM/WB tracking fields to 0, and both counters to 0.
REQ-027 While rst_n=0, Stall, Bubble, ForwardA and ForwardB SHALL read 0.
REQ-028 Reset assertion mid-HOLD SHALL abort HOLD immediately.
REQ-029 After reset release, the first posedge SHALL operate from RUN.

Structure
REQ-030 Package pipe_pkg SHALL hold fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10) and hz_state_e (RUN, HOLD).
REQ-031 The per-operand select SHALL be one sub-module, fwd_sel, instantiated twice (for rs1 and rs2).
REQ-032 Counters SHALL be inside hazard_ctrl; no further sub-modules.

Verification
REQ-033 The bench SHALL cover load-use: EX_MemToReg=1, EX_RegWrite=1, EX_rd=5, ID_rs2=5 -> Stall=1 and Bubble=1 for exactly 1 cycle, StallCount=1, then RUN.
REQ-034 The bench SHALL cover the x0 case: load with EX_rd=0 and ID_rs1=0 -> Stall=0; EX_RegWrite=1, EX_rd=0, EX_rs1=0 -> ForwardA=00 two cycles later.
REQ-035 The bench SHALL cover priority: ALU writes x3, then ALU writes x3, then EX_rs1=3 -> ForwardA=10; with only the older write -> ForwardA=01.
REQ-036 The bench SHALL cover flush versus hazard: Flush=1 together with a load-use hazard -> Bubble=1, Stall=0, FlushCount=1, StallCount unchanged.
REQ-037 The bench SHALL cover reset mid-HOLD: rst_n low during HOLD -> all outputs 0 at once and counters 0; after release, a hazard again gives a 1-cycle stall.
REQ-038 The bench SHALL cover saturation: with CNT_W=4, 20 stall cycles -> StallCount=15.
